// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter using shift-and-add-3
// (double dabble). One bit of the binary input is consumed per clock.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - conversion request, sampled only while idle
//   bin    - unsigned binary value, captured on the edge that accepts start
//   busy   - high while a conversion is in progress
//   done   - one-cycle pulse; bcd is new from this cycle
//   bcd    - packed BCD result, digit 0 (ones) in bits [3:0]
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
  function automatic bit digits_ok();
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (p > 64'hFFFF_FFFF) return 1'b1;
      p = p * 64'd10;
    end
    return p > ((64'd1 << WIDTH) - 64'd1);
  endfunction

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("bin2bcd_seq: WIDTH must be within 4..32");
  end
  if (!digits_ok()) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  logic [0:0]        state_q,   state_d;
  logic [WIDTH-1:0]  bin_sr_q,  bin_sr_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]     cnt_q,     cnt_d;
  logic [BW-1:0]     bcd_q,     bcd_d;
  logic              done_q,    done_d;

  logic [BW-1:0]       corr_c;
  logic [3:0]          dig_c;
  logic [BW+WIDTH-1:0] shifted_c;

  // Per-digit add-3 correction; digits are independent, no inter-digit carry.
  always_comb begin
    corr_c = '0;
    dig_c  = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dig_c = scratch_q[4*i +: 4];
      if (dig_c >= 4'd10)     corr_c[4*i +: 4] = 4'd0;
      else if (dig_c >= 4'd5) corr_c[4*i +: 4] = dig_c + 4'd3;
      else                    corr_c[4*i +: 4] = dig_c;
    end
  end

  // Shift {corrected scratch, bin_sr} left by one; bin_sr MSB enters scratch.
  assign shifted_c = {corr_c[BW-2:0], bin_sr_q, 1'b0};

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    bin_sr_d  = bin_sr_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_sr_d  = bin;
          scratch_d = '0;
          cnt_d     = CW'(WIDTH);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shifted_c[BW+WIDTH-1:WIDTH];
        bin_sr_d  = shifted_c[WIDTH-1:0];
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = shifted_c[BW+WIDTH-1:WIDTH];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_sr_q  <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_sr_q  <= bin_sr_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
    end
  end

  // busy is the state flop itself, so it stays a registered output.
  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq (WIDTH=16, DIGITS=5).
// Stimulus pushes hand-computed BCD results into a queue; a monitor pops and
// compares whenever done is seen.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;

  int checks   = 0;
  int failures = 0;
  logic [19:0] sb[$];

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(bcd), 32'hDEAD);
      end else begin
        check("bcd_result", 32'(bcd), 32'(sb.pop_front()));
      end
    end
  end

  // Follows a conversion from just after its accept edge up to the done cycle.
  // pa/pb: cycle numbers at which a one-cycle stray start is raised.
  task automatic run_conv(input logic [19:0] hold_val, input int pa, input int pb,
                          output int lat);
    int busy_cnt;
    int hold_err;
    int n;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    hold_err = 0;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == pa + 1 || n == pb + 1) begin
        start = 1'b0;
        bin   = 16'd0;
      end
      if (done === 1'b1) break;
      if (busy === 1'b1) busy_cnt++;
      if (bcd !== hold_val) hold_err++;
      if (n == pa || n == pb) begin
        start = 1'b1;
        bin   = 16'd1111;
      end
    end
    lat = n;
    check("latency", 32'(n), 32'd16);
    check("busy_cycles", 32'(busy_cnt), 32'd16);
    check("busy_low_at_done", 32'(busy), 32'd0);
    check("bcd_hold_errors", 32'(hold_err), 32'd0);
  endtask

  task automatic do_conv(input logic [15:0] v, input logic [19:0] exp,
                         input logic [19:0] hold_val, input int pa, input int pb);
    int lat;
    start = 1'b1;
    bin   = v;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    run_conv(hold_val, pa, pb, lat);
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int n;
    int done_seen;
    rst   = 1'b1;
    start = 1'b0;
    bin   = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd",  32'(bcd),  32'd0);
    rst = 1'b0;

    do_conv(16'd0,     20'h00000, 20'h00000, -5, -5);
    do_conv(16'd65535, 20'h65535, 20'h00000, -5, -5);
    do_conv(16'd1234,  20'h01234, 20'h65535, -5, -5);
    do_conv(16'd9,     20'h00009, 20'h01234, -5, -5);
    do_conv(16'd10000, 20'h10000, 20'h00009, -5, -5);
    // Stray starts during SHIFT must be ignored.
    do_conv(16'd4321,  20'h04321, 20'h10000, 3, 15);

    // Start held high through the done cycle: second conversion back to back.
    start = 1'b1;
    bin   = 16'd9999;
    sb.push_back(20'h09999);
    @(posedge clk);
    #1;
    bin = 16'd50000;
    sb.push_back(20'h50000);
    run_conv(20'h04321, -5, -5, lat);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_accept_busy", 32'(busy), 32'd1);
    check("b2b_accept_done", 32'(done), 32'd0);
    run_conv(20'h09999, -5, -5, n);
    check("b2b_spacing", 32'(n + 1), 32'd17);
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 32'd0);

    // Asynchronous reset in the middle of a conversion.
    start = 1'b1;
    bin   = 16'd777;
    sb.push_back(20'h00777);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_bcd",  32'(bcd),  32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    check("no_done_after_rst", 32'(done_seen), 32'd0);

    do_conv(16'd42, 20'h00042, 20'h00000, -5, -5);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits upstream of the 7-segment display path. It accepts an unsigned binary value on a start strobe and returns packed BCD digits with a one-cycle done pulse. Each iteration applies the per-digit add-3 correction to every BCD digit before the shift.

## Interface

Parameters:
- WIDTH, 16, bit width of the binary input; legal range 4..32.
- DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH - 1, and elaboration fails otherwise.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  WIDTH  unsigned binary value; sampled on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd is valid and new from this cycle.
- bcd  output  4*DIGITS  packed BCD result; digit 0 (ones) in bits [3:0], digit i in bits [4i+3:4i].

## Operation

- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- States:
  - IDLE: busy=0, waiting for start.
  - SHIFT: busy=1, performing iterations.
- Internal registers:
  - bin_sr: WIDTH-bit binary shift register.
  - scratch: 4*DIGITS-bit BCD accumulator.
  - cnt: iteration counter, ceil(log2(WIDTH+1)) bits.
- IDLE and start=1:
  - bin_sr <= bin, scratch <= 0, cnt <= WIDTH; go to SHIFT.
- SHIFT, each edge:
  - Form corrected scratch: every digit d with d >= 5 becomes d+3 (4-bit); digits 0..4 are unchanged.
  - Digits 10..15 cannot occur. The correction maps them to 0, but no behaviour depends on it.
  - Shift {corrected scratch, bin_sr} left by one; the bin_sr MSB enters scratch bit 0 and bin_sr bit 0 gets 0.
  - cnt <= cnt-1.
- SHIFT with cnt == 1 (final iteration):
  - bcd <= the shifted result, done <= 1; go to IDLE.
- done is registered and high for exactly one cycle after the final edge.
- bcd holds the last completed result. It is not cleared by start and changes only on the final-iteration edge.
- start while in SHIFT is ignored and not queued; bin changes during SHIFT have no effect.
- start in the cycle where done=1 is accepted, since the state is IDLE. done drops and busy rises on that edge.
- Reset, asynchronous, including mid-conversion:
  - state=IDLE, busy=0, done=0, bcd=0, scratch=0, bin_sr=0, cnt=0.
  - Any in-flight conversion is discarded and no done is produced.
- Reset release: the first edge with rst low may accept start.

## Timing

- Edge E0 accepts start. Iterations happen on edges E1..E_WIDTH.
- busy is high from after E0 until E_WIDTH.
- bcd and done update on E_WIDTH: done=1 during the cycle after E_WIDTH, then 0.
- Latency from the start-accept edge to done assertion: WIDTH clocks (16 by default).
- Throughput: one conversion per WIDTH+1 clocks if start is held high continuously; back-to-back starts give this too.
- All outputs are registered with no combinational path from inputs to outputs.
- Critical path per cycle: one 4-bit >=5 compare plus add per digit, in parallel, then a wire shift. There is no carry chain between digits.

## Test plan

- Reset, then start with bin=0 → busy high for 16 cycles; done pulses once at cycle 16; bcd=20'h00000.
- bin=16'd65535 → after 16 cycles bcd=20'h65535, done high exactly one cycle, busy low in the same cycle.
- Sequential bins 16'd1234, 16'd9, 16'd10000 → bcd=20'h01234, 20'h00009, 20'h10000. Each bcd holds until the next done.
- Start with bin=16'd4321. Assert start again at cycles 3 and 15 with bin=16'd1111 → only one done; bcd=20'h04321; busy timing unchanged.
- Start with bin=16'd9999 and hold start=1 through the done cycle with bin=16'd50000 → first done with bcd=20'h09999; second conversion accepted on the done cycle; second done 17 cycles after the first with bcd=20'h50000.
- Start a conversion and assert rst asynchronously (mid-cycle) at iteration 8 → busy, done and bcd go to 0 immediately. No done follows, and the next start converts normally.
